// File: rtl/vend_credit_controller_if.sv
// -----------------------------------------------------------------------------
// vend_credit_controller_if
//
// Purpose:
//   Bundles the front-end inputs (coin acceptor and keypad) and the
//   back-end handshakes (dispenser and hopper) of the vending credit
//   controller. The clock and reset stay outside as plain ports.
//
// Signals:
//   hundred_in, fifty_in   coin pulses                       (front end -> ctrl)
//   sel_valid, sel_item    item selection strobe and item    (front end -> ctrl)
//   cancel                 refund request                    (front end -> ctrl)
//   vend_valid, vend_item  dispense request and item         (ctrl -> dispenser)
//   vend_ready             dispenser accepts the request     (dispenser -> ctrl)
//   change_valid           one 50 token pending              (ctrl -> hopper)
//   change_ready           hopper ejected one token          (hopper -> ctrl)
//   coin_reject            return the previous cycle's coin  (ctrl -> acceptor)
//   credit                 current credit in 50-units        (ctrl -> display)
//   busy                   controller is vending or paying   (ctrl -> front end)
//
// Modports:
//   slave  - the controller's view
//   master - the environment's view (front end, dispenser, hopper)
// -----------------------------------------------------------------------------
interface vend_credit_controller_if #(
    parameter int CW = 4
);
    logic          hundred_in;
    logic          fifty_in;
    logic          sel_valid;
    logic          sel_item;
    logic          cancel;
    logic          vend_valid;
    logic          vend_item;
    logic          vend_ready;
    logic          change_valid;
    logic          change_ready;
    logic          coin_reject;
    logic [CW-1:0] credit;
    logic          busy;

    modport slave (
        input  hundred_in,
        input  fifty_in,
        input  sel_valid,
        input  sel_item,
        input  cancel,
        input  vend_ready,
        input  change_ready,
        output vend_valid,
        output vend_item,
        output change_valid,
        output coin_reject,
        output credit,
        output busy
    );

    modport master (
        output hundred_in,
        output fifty_in,
        output sel_valid,
        output sel_item,
        output cancel,
        output vend_ready,
        output change_ready,
        input  vend_valid,
        input  vend_item,
        input  change_valid,
        input  coin_reject,
        input  credit,
        input  busy
    );
endinterface

// File: rtl/vend_credit_controller.sv
// -----------------------------------------------------------------------------
// vend_credit_controller
//
// Purpose:
//   Sequencing controller for the coin vending path. Accumulates credit from
//   50/100 coin pulses (credit is kept in units of 50), lets the customer buy
//   item A or item B, issues one dispense request per purchase through a
//   valid/ready handshake, and hands back remaining credit as single 50-unit
//   tokens through the hopper handshake. An idle customer is refunded
//   automatically after TIMEOUT_CYC cycles without an accepted coin.
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   reset  synchronous, active-high reset
//   bus    vend_credit_controller_if.slave (coins, selection, cancel,
//          dispense and change handshakes, coin_reject, credit, busy)
//
// Parameters:
//   PRICE_A     price of item A in 50-units
//   PRICE_B     price of item B in 50-units
//   MAX_CREDIT  highest credit accepted, in 50-units
//   TIMEOUT_CYC idle cycles in CREDIT before automatic refund
//   CW          credit width, must hold MAX_CREDIT+2
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module vend_credit_controller #(
    parameter int PRICE_A     = 3,
    parameter int PRICE_B     = 2,
    parameter int MAX_CREDIT  = 6,
    parameter int TIMEOUT_CYC = 255,
    parameter int CW          = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    vend_credit_controller_if.slave  bus
);

    // Timer must be able to count up to TIMEOUT_CYC-1.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [CW-1:0] PRICE_A_C    = CW'(PRICE_A);
    localparam logic [CW-1:0] PRICE_B_C    = CW'(PRICE_B);
    localparam logic [CW-1:0] MAX_CREDIT_C = CW'(MAX_CREDIT);
    localparam logic [CW-1:0] CREDIT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CREDIT_ONE   = CW'(1'b1);
    localparam logic [TW-1:0] TIMER_ZERO   = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1'b1);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_e;

    // Value of a coin cycle in 50-units; zero unless exactly one line is high.
    function automatic logic [CW-1:0] coin_value(input logic hundred, input logic fifty);
        logic [CW-1:0] v;
        v = CREDIT_ZERO;
        if (hundred && !fifty) begin
            v = CW'(2'd2);
        end else if (fifty && !hundred) begin
            v = CW'(2'd1);
        end else begin
            v = CREDIT_ZERO;
        end
        return v;
    endfunction

    state_e        state_q,        state_d;
    logic [CW-1:0] credit_q,       credit_d;
    logic [TW-1:0] timer_q,        timer_d;
    logic          vend_valid_q,   vend_valid_d;
    logic          vend_item_q,    vend_item_d;
    logic          change_valid_q, change_valid_d;
    logic          coin_reject_q,  coin_reject_d;
    logic          busy_q,         busy_d;

    logic          coin_any_s;
    logic          coin_accept_s;
    logic [CW-1:0] coin_val_s;
    logic [CW-1:0] credit_sum_s;
    logic [CW-1:0] price_s;

    // Coin qualification and price lookup for the current cycle.
    always_comb begin
        coin_any_s    = bus.hundred_in | bus.fifty_in;
        coin_val_s    = coin_value(bus.hundred_in, bus.fifty_in);
        // MAX_CREDIT+2 fits in CW bits, so this sum cannot wrap.
        credit_sum_s  = credit_q + coin_val_s;
        price_s       = bus.sel_item ? PRICE_B_C : PRICE_A_C;
        coin_accept_s = 1'b0;
        // A coin is only taken while collecting credit and when nothing else
        // competes for the same cycle; everything else goes back to the user.
        if (((state_q == ST_IDLE) || (state_q == ST_CREDIT)) &&
            (bus.hundred_in ^ bus.fifty_in) &&
            !bus.sel_valid && !bus.cancel &&
            (credit_sum_s <= MAX_CREDIT_C)) begin
            coin_accept_s = 1'b1;
        end else begin
            coin_accept_s = 1'b0;
        end
    end

    // Next-state and next-output logic of the controller FSM.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        timer_d        = timer_q;
        vend_valid_d   = vend_valid_q;
        vend_item_d    = vend_item_q;
        change_valid_d = change_valid_q;
        coin_reject_d  = coin_any_s & ~coin_accept_s;

        case (state_q)
            ST_IDLE: begin
                // sel_valid and cancel have nothing to act on with zero credit.
                timer_d        = TIMER_ZERO;
                vend_valid_d   = 1'b0;
                change_valid_d = 1'b0;
                if (coin_accept_s) begin
                    credit_d = credit_sum_s;
                    state_d  = ST_CREDIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_CREDIT: begin
                if (bus.cancel) begin
                    state_d        = ST_CHANGE;
                    change_valid_d = (credit_q != CREDIT_ZERO);
                    timer_d        = TIMER_ZERO;
                end else if (bus.sel_valid && (credit_q >= price_s)) begin
                    credit_d     = credit_q - price_s;
                    vend_item_d  = bus.sel_item;
                    vend_valid_d = 1'b1;
                    state_d      = ST_VEND;
                    timer_d      = TIMER_ZERO;
                end else if (coin_accept_s) begin
                    credit_d = credit_sum_s;
                    timer_d  = TIMER_ZERO;
                end else if (timer_q == TIMER_LAST) begin
                    // This idle cycle brings the count to TIMEOUT_CYC: refund.
                    state_d        = ST_CHANGE;
                    change_valid_d = (credit_q != CREDIT_ZERO);
                    timer_d        = TIMER_ZERO;
                end else begin
                    // Includes an unaffordable selection, which is ignored.
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            ST_VEND: begin
                timer_d = TIMER_ZERO;
                if (vend_valid_q && bus.vend_ready) begin
                    vend_valid_d = 1'b0;
                    if (credit_q != CREDIT_ZERO) begin
                        state_d        = ST_CHANGE;
                        change_valid_d = 1'b1;
                    end else begin
                        state_d        = ST_IDLE;
                        change_valid_d = 1'b0;
                    end
                end else begin
                    vend_valid_d = 1'b1;
                end
            end

            ST_CHANGE: begin
                timer_d = TIMER_ZERO;
                if (credit_q == CREDIT_ZERO) begin
                    // Nothing left to return; do not linger here.
                    state_d        = ST_IDLE;
                    change_valid_d = 1'b0;
                end else if (change_valid_q && bus.change_ready) begin
                    credit_d = credit_q - CREDIT_ONE;
                    if (credit_q == CREDIT_ONE) begin
                        // Last token: drop valid on the same edge credit hits 0.
                        state_d        = ST_IDLE;
                        change_valid_d = 1'b0;
                    end else begin
                        change_valid_d = 1'b1;
                    end
                end else begin
                    change_valid_d = 1'b1;
                end
            end

            default: begin
                state_d        = ST_IDLE;
                credit_d       = CREDIT_ZERO;
                timer_d        = TIMER_ZERO;
                vend_valid_d   = 1'b0;
                vend_item_d    = 1'b0;
                change_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= CREDIT_ZERO;
            timer_q        <= TIMER_ZERO;
            vend_valid_q   <= 1'b0;
            vend_item_q    <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            timer_q        <= timer_d;
            vend_valid_q   <= vend_valid_d;
            vend_item_q    <= vend_item_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_item    = vend_item_q;
    assign bus.change_valid = change_valid_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = busy_q;

endmodule
